// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - unpacks 3-word/4-pixel video stream into one RGB pixel per handshake
// Optional framing checks (sof_err/eol_err) are built when PIXEL_UNPACKER_CHECK_EN is defined.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        sof,
  output logic        eol,
  output logic        valid,
  input  logic        ready,
  output logic        sof_err,
  output logic        eol_err,
  output logic [15:0] frame_count
);

  localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
  localparam logic [15:0] X_PRE  = 16'(X_SIZE - 2);
  localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e      phase_q, phase_d, eff_phase;
  logic [23:0] residue_q, residue_d;
  logic [23:0] pix_q, pix_d;
  logic [15:0] cx_q, cy_q, pos_x, pos_y, nx, ny;
  logic [15:0] x_q, y_q, frame_count_q;
  logic        sof_q, eol_q, valid_q, sof_err_q, eol_err_q;
  logic        load, accept, emit, x_wrap, frame_inc, sof_bad, eol_bad;

`ifdef PIXEL_UNPACKER_CHECK_EN
  logic unused_in;
  assign unused_in = ^in_stream_tkeep;
`else
  logic unused_in;
  assign unused_in = ^{in_stream_tkeep, in_stream_tuser, in_stream_tlast};
`endif

  always_comb begin
    load             = !valid_q | ready;
    in_stream_tready = !areset & (phase_q != PH3) & load;
    accept           = in_stream_tvalid & in_stream_tready;
    emit             = accept | ((phase_q == PH3) & load);
    eff_phase        = phase_q;
    pos_x            = cx_q;
    pos_y            = cy_q;
    sof_bad          = 1'b0;
    eol_bad          = 1'b0;
`ifdef PIXEL_UNPACKER_CHECK_EN
    // A misplaced start-of-frame resynchronises: the word becomes W0 of pixel (0,0).
    sof_bad = accept & in_stream_tuser & ((phase_q != PH0) | (cx_q != 16'd0) | (cy_q != 16'd0));
    if (sof_bad) begin
      eff_phase = PH0;
      pos_x     = 16'd0;
      pos_y     = 16'd0;
    end
    eol_bad = accept & (in_stream_tlast != ((eff_phase == PH2) & (pos_x == X_PRE)));
`endif
    pix_d     = residue_q;
    residue_d = residue_q;
    phase_d   = PH0;
    case (eff_phase)
      PH0: begin
        pix_d     = in_stream_tdata[23:0];
        residue_d = {residue_q[23:8], in_stream_tdata[31:24]};
        phase_d   = PH1;
      end
      PH1: begin
        pix_d     = {in_stream_tdata[15:0], residue_q[7:0]};
        residue_d = {residue_q[23:16], in_stream_tdata[31:16]};
        phase_d   = PH2;
      end
      PH2: begin
        pix_d     = {in_stream_tdata[7:0], residue_q[15:0]};
        residue_d = in_stream_tdata[31:8];
        phase_d   = PH3;
      end
      default: begin
        pix_d   = residue_q;
        phase_d = PH0;
      end
    endcase
    x_wrap    = (pos_x == X_LAST);
    frame_inc = x_wrap & (pos_y == Y_LAST);
    nx        = x_wrap ? 16'd0 : pos_x + 16'd1;
    ny        = x_wrap ? ((pos_y == Y_LAST) ? 16'd0 : pos_y + 16'd1) : pos_y;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      phase_q       <= PH0;
      residue_q     <= '0;
      pix_q         <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      valid_q       <= 1'b0;
      sof_err_q     <= 1'b0;
      eol_err_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      sof_err_q <= sof_bad;
      eol_err_q <= eol_bad;
      if (emit) begin
        phase_q   <= phase_d;
        residue_q <= residue_d;
        pix_q     <= pix_d;
        x_q       <= pos_x;
        y_q       <= pos_y;
        sof_q     <= (pos_x == 16'd0) & (pos_y == 16'd0);
        eol_q     <= x_wrap;
        valid_q   <= 1'b1;
        cx_q      <= nx;
        cy_q      <= ny;
        if (frame_inc) frame_count_q <= frame_count_q + 16'd1;
      end else if (ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign r           = pix_q[23:16];
  assign g           = pix_q[15:8];
  assign b           = pix_q[7:0];
  assign x           = x_q;
  assign y           = y_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign valid       = valid_q;
  assign sof_err     = sof_err_q;
  assign eol_err     = eol_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/pixel_unpacker.md
# pixel_unpacker

Receive-side counterpart of the pixel generator's stream output. The block accepts the packed 32-bit AXI-Stream video format (4 × 24-bit pixels in 3 words, tuser = start-of-frame, tlast = end-of-line) and unpacks it back into one RGB pixel per handshake with sof/eol markers and x/y tracking. It also checks framing. It sits in loopback/verification paths and in any downstream consumer of generated frames.

## Interface

**Parameters**
- `X_SIZE`, default 640: pixels per line; must be a multiple of 4.
- `Y_SIZE`, default 480: lines per frame.

**Ports**

Clock and reset: one clock; reset is synchronous and active-high.
- `aclk`, in, 1: clock for all logic.
- `areset`, in, 1: synchronous, active-high reset.

Input stream:
- `in_stream_tdata`, in, 32: packed pixel bytes.
- `in_stream_tkeep`, in, 4: ignored; producer always drives 4'hF.
- `in_stream_tlast`, in, 1: end of line; valid on the third word of the last pixel group.
- `in_stream_tuser`, in, 1: start of frame; valid on the first word of the frame.
- `in_stream_tvalid`, in, 1: input word valid.
- `in_stream_tready`, out, 1: block can accept a word.

Pixel output:
- `r`, `g`, `b`, out, 8 each: unpacked pixel.
- `x`, out, 16: column of the presented pixel.
- `y`, out, 16: row of the presented pixel.
- `sof`, out, 1: presented pixel is (0,0).
- `eol`, out, 1: presented pixel is x = X_SIZE-1.
- `valid`, out, 1: pixel presented.
- `ready`, in, 1: downstream accepts the pixel.

Status:
- `sof_err`, out, 1: one-cycle pulse on a framing error (start of frame).
- `eol_err`, out, 1: one-cycle pulse on a framing error (end of line).
- `frame_count`, out, 16: completed frames; wraps.

## Operation
- Pixel word P = {r, g, b}, so r is P[23:16] and b is P[7:0].
- Packing, words W0..W2 carrying pixels P0..P3:
  - W0 = {P1[7:0], P0}
  - W1 = {P2[15:0], P1[23:8]}
  - W2 = {P3, P2[23:16]}
- Phase state machine (2 bits) plus a 24-bit residue register:
  - PH0: accept word; emit P0 = w[23:0]; residue[7:0] = w[31:24]; go to PH1.
  - PH1: accept word; emit {w[15:0], residue[7:0]}; residue[15:0] = w[31:16]; go to PH2.
  - PH2: accept word; emit {w[7:0], residue[15:0]}; residue = w[31:8]; go to PH3.
  - PH3: no input word; emit residue; go to PH0.
- Output register is single-entry.
  - It loads when empty, or when its current pixel is taken (`valid & ready`) in the same cycle.
  - `in_stream_tready = !areset & (phase != PH3) & (!valid | ready)`.
- x/y counters advance on each output load.
  - x wraps at X_SIZE-1 to 0, then y increments.
  - y wraps at Y_SIZE-1 to 0 and `frame_count` increments.
  - sof, eol and x/y are computed from the counter value loaded with the pixel.
- Tracking: the `sof`, `eol`, x/y outputs always derive from the counters.

## Timing
- Reset values:
  - `valid`, `in_stream_tready`, `sof`, `eol`, `sof_err`, `eol_err` = 0.
  - `r`, `g`, `b`, `x`, `y`, `frame_count` = 0.
  - Phase = PH0, residue = 0.
- Reset mid-group discards the residue and any presented pixel. The next accepted word is treated as W0.
- Latency: word accepted at edge N → pixel valid from cycle N+1.
- The PH3 pixel loads on the edge at which the PH2 pixel is taken.
- Sustained throughput with `ready` held at 1: 1 pixel/cycle and 3 words per 4 cycles; tready is low in PH3.
- `valid` and pixel data hold stable until `ready`; there is no combinational path from `ready` to the data outputs.
- Simultaneous take and load in one cycle gives no bubble.

## Configuration
- Macro: `PIXEL_UNPACKER_CHECK_EN`.
- Defined — framing checks are active:
  - tuser accepted while not in PH0 or not at (0,0): pulse `sof_err`, force phase to PH0, treat the word as W0 of pixel (0,0).
  - tuser accepted exactly at (0,0) in PH0: no error.
  - tlast value differing from (PH2 word whose P3 has x = X_SIZE-1): pulse `eol_err`; no resync.
- Undefined: tuser/tlast are ignored; `sof_err` = `eol_err` = 0 constantly; behaviour is purely counter-driven.

## Test plan
- Stream one 640×480 frame, ready = 1 → 307200 pixels.
  - 4-cycle repeat: tready = 1,1,1,0.
  - Words 0x33_221100, 0x5544_3322…: P0 = 0x221100.
  - sof on first pixel only, eol at x = 639, `frame_count` = 1 at end.
- Pack pixels 0x0A0B0C, 0x1A1B1C, 0x2A2B2C, 0x3A3B3C → outputs in order with exact r/g/b.
  - Hold ready = 0 for 5 cycles after the second pixel → pixel 2 held stable, tready = 0, no loss.
- (CHECK_EN) tuser on the word at pixel (100,3) → `sof_err` one-cycle pulse, next pixel x = 0, y = 0, sof = 1.
- (CHECK_EN) tlast withheld on line 0's final word → `eol_err` pulse; counters continue at (0,1).
- Assert areset after W1 accepted → all outputs 0 next cycle; next word decoded as W0 with x = 0, y = 0.
- Run 65536 frames at X_SIZE = 4, Y_SIZE = 1 → `frame_count` wraps to 0.
